// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream request port between N_MASTERS requesters.
//   Arbitration is round-robin, and only one transaction can be in flight.
//   The winning request is captured into registers and presented downstream.
//   The response is then routed back to the master that owns the transaction.
//   A watchdog ends any transaction whose response never arrives. It returns
//   an error response to the owner.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   m_req_i / m_gnt_o       per-master request valid / one-hot grant (IDLE only)
//   m_addr_i, m_wdata_i,
//   m_we_i, m_be_i          flattened per-master request fields (slice k = master k)
//   m_rvalid_o              one-hot response strobe to the owner
//   m_rdata_o, m_err_o      response data / error, valid with m_rvalid_o
//   s_req_o / s_gnt_i       downstream request valid / accept
//   s_addr_o, s_wdata_o,
//   s_we_o, s_be_o          registered downstream request fields
//   s_rvalid_i, s_rdata_i,
//   s_err_i                 downstream response
//   busy_o                  a transaction is in progress
//   owner_o                 index of the current/last owner
module mem_port_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int SEL_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [N_MASTERS-1:0]          m_req_i,
    output logic [N_MASTERS-1:0]          m_gnt_o,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_be_i,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          m_err_o,
    output logic                          s_req_o,
    input  logic                          s_gnt_i,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic                          s_we_o,
    output logic [DATA_W/8-1:0]           s_be_o,
    input  logic                          s_rvalid_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    input  logic                          s_err_i,
    output logic                          busy_o,
    output logic [SEL_W-1:0]              owner_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                              state_q, state_d;
    logic [SEL_W-1:0]                    last_q, owner_q, win_idx;
    logic                                win_vld;
    logic [CNT_W-1:0]                    cnt_q;

    // Reshape the flattened request buses so the winner can be indexed directly.
    logic [N_MASTERS-1:0][ADDR_W-1:0]    addr_v;
    logic [N_MASTERS-1:0][DATA_W-1:0]    wdata_v;
    logic [N_MASTERS-1:0][BE_W-1:0]      be_v;

    assign addr_v  = m_addr_i;
    assign wdata_v = m_wdata_i;
    assign be_v    = m_be_i;

    // Round-robin search that starts just after the last winner.
    // last_q+1+i is at most 2N-1, so a single conditional subtract wraps it.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(last_q) + 1 + i;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!win_vld && m_req_i[idx[SEL_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    m_gnt_o = N_MASTERS'(1) << win_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_gnt_i) state_d = RESP;
            end
            RESP: begin
                // A real response takes priority over the watchdog in the same cycle.
                if (s_rvalid_i) begin
                    m_rvalid_o = N_MASTERS'(1) << owner_q;
                    m_rdata_o  = s_rdata_i;
                    m_err_o    = s_err_i;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    m_rvalid_o = N_MASTERS'(1) << owner_q;
                    m_err_o    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            last_q    <= SEL_W'(N_MASTERS - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_we_o    <= 1'b0;
            s_be_o    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_vld) begin
                s_addr_o  <= addr_v[win_idx];
                s_wdata_o <= wdata_v[win_idx];
                s_we_o    <= m_we_i[win_idx];
                s_be_o    <= be_v[win_idx];
                owner_q   <= win_idx;
                last_q    <= win_idx;
            end
            // On the exit cycle the counter may wrap. This is harmless because
            // it is cleared again before the next RESP phase.
            if (state_q == REQ && s_gnt_i)
                cnt_q <= '0;
            else if (state_q == RESP)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign s_req_o = (state_q == REQ);
    assign busy_o  = (state_q != IDLE);
    assign owner_o = owner_q;

endmodule
